rob_ring: RTL and testbench

Parametrised in-order-retire ring buffer for the RISC-V core's reorder stage. It is the successor to the plain data ring buffer.
- Entries are allocated at the tail in program order and return a slot index.
- Entries are marked complete out of order by index through a write-back port.
- Entries retire from the head through a valid/ready handshake, only once complete.
- The block adds full/empty/count status and a global flush.

---
 rtl/rob_ring.sv | 162 ++++++++++++++++
 tb/tb_rob_ring.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ring.sv
// In-order-retire reorder ring: allocate at tail, complete out of order by slot, retire from head.
// Optional ROB_RING_EXC_EN adds a per-entry exception bit; retiring an excepting entry flushes the ring.
module rob_ring #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_alloc,
    input  logic [WIDTH-1:0] i_alloc_data,
    output logic             o_alloc_rdy,
    output logic [AW-1:0]    o_alloc_idx,
    input  logic             i_wb_en,
    input  logic [AW-1:0]    i_wb_idx,
`ifdef ROB_RING_EXC_EN
    input  logic             i_wb_exc,
    output logic             o_ret_exc,
`endif
    output logic             o_ret_vld,
    input  logic             i_ret_rdy,
    output logic [WIDTH-1:0] o_ret_data,
    output logic [AW-1:0]    o_ret_idx,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      head_reg, head_next;
    logic [AW:0]      tail_reg, tail_next;
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] done_reg, done_next;
    logic [DEPTH-1:0] data_we;
    logic [WIDTH-1:0] data_reg [DEPTH];

    logic [AW-1:0]    head_idx;
    logic [AW-1:0]    tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             ret_vld;
    logic             ret_fire;
    logic             exc_flush;
    logic             clear_all;

    assign head_idx   = head_reg[AW-1:0];
    assign tail_idx   = tail_reg[AW-1:0];
    assign full       = (head_idx == tail_idx) && (head_reg[AW] != tail_reg[AW]);
    assign ret_vld    = valid_reg[head_idx] && done_reg[head_idx];
    assign alloc_fire = i_alloc && !full;
    assign ret_fire   = ret_vld && i_ret_rdy;
    assign clear_all  = i_flush || exc_flush;

`ifdef ROB_RING_EXC_EN
    logic [DEPTH-1:0] exc_reg, exc_next;

    assign exc_flush = ret_fire && exc_reg[head_idx];
    assign o_ret_exc = ret_vld && exc_reg[head_idx];
`else
    assign exc_flush = 1'b0;
`endif

    // Per-slot next-state: flush beats alloc beats retire beats write-back.
    // Alloc and retire never target the same slot in one cycle (alloc needs !full, retire needs !empty).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] SLOT = AW'(gi);
            logic alloc_hit;
            logic ret_hit;
            logic wb_hit;

            assign alloc_hit = alloc_fire && (tail_idx == SLOT);
            assign ret_hit   = ret_fire && (head_idx == SLOT);
            assign wb_hit    = i_wb_en && (i_wb_idx == SLOT) && valid_reg[gi];
            assign data_we[gi] = alloc_hit && !clear_all;

            assign valid_next[gi] = clear_all ? 1'b0 :
                                    alloc_hit ? 1'b1 :
                                    ret_hit   ? 1'b0 :
                                                valid_reg[gi];

            assign done_next[gi]  = clear_all ? 1'b0 :
                                    alloc_hit ? 1'b0 :
                                    ret_hit   ? 1'b0 :
                                    wb_hit    ? 1'b1 :
                                                done_reg[gi];
`ifdef ROB_RING_EXC_EN
            assign exc_next[gi]   = clear_all ? 1'b0 :
                                    alloc_hit ? 1'b0 :
                                    ret_hit   ? 1'b0 :
                                    wb_hit    ? (exc_reg[gi] | i_wb_exc) :
                                                exc_reg[gi];
`endif
        end
    endgenerate

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (clear_all) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (ret_fire) begin
                head_next = head_reg + (AW+1)'(1);
            end
            if (alloc_fire) begin
                tail_next = tail_reg + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

`ifdef ROB_RING_EXC_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exc_reg <= '0;
        end else begin
            exc_reg <= exc_next;
        end
    end
`endif

    // Payload is cleared on reset so the head slot reads zero out of reset; flush leaves it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (data_we[i]) begin
                    data_reg[i] <= i_alloc_data;
                end
            end
        end
    end

    assign o_alloc_rdy = !full;
    assign o_alloc_idx = tail_idx;
    assign o_ret_vld   = ret_vld;
    assign o_ret_data  = data_reg[head_idx];
    assign o_ret_idx   = head_idx;
    assign o_full      = full;
    assign o_empty     = (head_reg == tail_reg);
    assign o_count     = tail_reg - head_reg;

endmodule

// File: tb/tb_rob_ring.sv
// Bench for rob_ring: a queue-of-entries model checked every cycle, plus directed literal checks.
module tb_rob_ring;
    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_alloc = 1'b0;
    logic [WIDTH-1:0] i_alloc_data = '0;
    logic             o_alloc_rdy;
    logic [AW-1:0]    o_alloc_idx;
    logic             i_wb_en = 1'b0;
    logic [AW-1:0]    i_wb_idx = '0;
`ifdef ROB_RING_EXC_EN
    logic             i_wb_exc = 1'b0;
    logic             o_ret_exc;
`endif
    logic             o_ret_vld;
    logic             i_ret_rdy = 1'b0;
    logic [WIDTH-1:0] o_ret_data;
    logic [AW-1:0]    o_ret_idx;
    logic             i_flush = 1'b0;
    logic             o_full;
    logic             o_empty;
    logic [AW:0]      o_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    rob_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alloc(i_alloc), .i_alloc_data(i_alloc_data),
        .o_alloc_rdy(o_alloc_rdy), .o_alloc_idx(o_alloc_idx),
        .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx),
`ifdef ROB_RING_EXC_EN
        .i_wb_exc(i_wb_exc), .o_ret_exc(o_ret_exc),
`endif
        .o_ret_vld(o_ret_vld), .i_ret_rdy(i_ret_rdy),
        .o_ret_data(o_ret_data), .o_ret_idx(o_ret_idx),
        .i_flush(i_flush), .o_full(o_full), .o_empty(o_empty), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the ring is just an ordered list of live entries plus the next slot number.
    typedef struct {
        int idx;
        int data;
        bit done;
        bit exc;
    } ent_t;
    ent_t mq[$];
    int   m_tail = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        bit rv, rf, af, xf;
        ent_t e;
        if (!i_rst_n) begin
            mq.delete();
            m_tail = 0;
        end else begin
            rv = (mq.size() > 0) && mq[0].done;
            rf = rv && i_ret_rdy;
            af = i_alloc && (mq.size() < DEPTH);
            xf = 0;
`ifdef ROB_RING_EXC_EN
            xf = rf && mq[0].exc;
`endif
            if (i_flush || xf) begin
                mq.delete();
                m_tail = 0;
            end else begin
                if (i_wb_en) begin
                    foreach (mq[k]) begin
                        if (mq[k].idx == int'(i_wb_idx)) begin
                            mq[k].done = 1;
`ifdef ROB_RING_EXC_EN
                            mq[k].exc = mq[k].exc | i_wb_exc;
`endif
                        end
                    end
                end
                if (rf) void'(mq.pop_front());
                if (af) begin
                    e.idx = m_tail; e.data = int'(i_alloc_data); e.done = 0; e.exc = 0;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        int sz;
        bit ev;
        if (i_rst_n && chk_en) begin
            sz = mq.size();
            ev = (sz > 0) && mq[0].done;
            chk("count", int'(o_count), sz);
            chk("empty", int'(o_empty), int'(sz == 0));
            chk("full", int'(o_full), int'(sz == DEPTH));
            chk("alloc_rdy", int'(o_alloc_rdy), int'(sz != DEPTH));
            chk("alloc_idx", int'(o_alloc_idx), m_tail);
            chk("ret_vld", int'(o_ret_vld), int'(ev));
            chk("ret_idx", int'(o_ret_idx), (m_tail - sz + 2*DEPTH) % DEPTH);
            if (ev) chk("ret_data", int'(o_ret_data), mq[0].data);
`ifdef ROB_RING_EXC_EN
            chk("ret_exc", int'(o_ret_exc), int'(ev && mq[0].exc));
`endif
        end
    end

    task automatic drive(input bit a, input int d, input bit w, input int wi,
                         input bit r, input bit f, input bit x = 0);
        i_alloc = a; i_alloc_data = WIDTH'(d);
        i_wb_en = w; i_wb_idx = AW'(wi);
        i_ret_rdy = r; i_flush = f;
`ifdef ROB_RING_EXC_EN
        i_wb_exc = x;
`else
        if (x) $display("note: exc stimulus ignored in this build");
`endif
        @(posedge i_clk);
        #1;
        i_alloc = 0; i_wb_en = 0; i_ret_rdy = 0; i_flush = 0;
`ifdef ROB_RING_EXC_EN
        i_wb_exc = 0;
`endif
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        chk_en = 1;
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_count", int'(o_count), 0);
        chk("rst_alloc_rdy", int'(o_alloc_rdy), 1);
        chk("rst_ret_vld", int'(o_ret_vld), 0);
        chk("rst_alloc_idx", int'(o_alloc_idx), 0);
        chk("rst_ret_data", int'(o_ret_data), 0);

        // Fill to DEPTH, then one refused alloc.
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_idx", int'(o_alloc_idx), i);
            drive(1, i, 0, 0, 0, 0);
        end
        chk("fill_full", int'(o_full), 1);
        chk("fill_rdy", int'(o_alloc_rdy), 0);
        drive(1, 5, 0, 0, 0, 0);
        chk("over_count", int'(o_count), 16);

        // Full with completed head: alloc and retire together -> retire only.
        drive(0, 0, 1, 0, 0, 0);
        chk("wrap_vld", int'(o_ret_vld), 1);
        chk("wrap_data", int'(o_ret_data), 0);
        drive(1, 9, 0, 0, 1, 0);
        chk("wrap_count", int'(o_count), 15);
        chk("wrap_tail", int'(o_alloc_idx), 0);
        drive(1, 10, 0, 0, 0, 0);
        chk("wrap_full", int'(o_full), 1);
        chk("wrap_head", int'(o_ret_idx), 1);

        // Flush with 5 entries and coincident alloc and write-back.
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, i + 7, 0, 0, 0, 0);
        chk("pre_flush_count", int'(o_count), 5);
        drive(1, 3, 1, 0, 0, 1);
        chk("flush_empty", int'(o_empty), 1);
        chk("flush_count", int'(o_count), 0);
        chk("flush_idx", int'(o_alloc_idx), 0);
        chk("flush_vld", int'(o_ret_vld), 0);

        // Out-of-order completion, in-order retire.
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 0);
        chk("ooo_hold", int'(o_ret_vld), 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("ooo_vld0", int'(o_ret_vld), 1);
        chk("ooo_idx0", int'(o_ret_idx), 0);
        drive(0, 0, 1, 1, 1, 0);
        chk("ooo_idx1", int'(o_ret_idx), 1);
        chk("ooo_data1", int'(o_ret_data), 4);
        drive(0, 0, 0, 0, 1, 0);
        chk("ooo_idx2", int'(o_ret_idx), 2);
        chk("ooo_data2", int'(o_ret_data), 5);
        drive(0, 0, 0, 0, 1, 0);
        chk("ooo_empty", int'(o_empty), 1);

        // Write-back to a not-yet-allocated slot is ignored.
        drive(0, 0, 1, 3, 0, 0);
        drive(1, 6, 0, 0, 0, 0);
        chk("stale_wb", int'(o_ret_vld), 0);
        drive(0, 0, 0, 0, 0, 1);

        // Mixed traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset mid-operation.
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, i, 0, 0, 0, 0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_count", int'(o_count), 0);
        chk("arst_empty", int'(o_empty), 1);
        chk("arst_idx", int'(o_alloc_idx), 0);
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;

`ifdef ROB_RING_EXC_EN
        for (int i = 0; i < 4; i++) drive(1, i + 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0);
        chk("exc_idx0", int'(o_ret_exc), 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("exc_idx1", int'(o_ret_exc), 1);
        chk("exc_head", int'(o_ret_idx), 1);
        drive(1, 9, 1, 2, 1, 0);
        chk("exc_empty", int'(o_empty), 1);
        chk("exc_tail", int'(o_alloc_idx), 0);
`endif

        drive(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
